// File: rtl/mem_block_mover.sv
// Block-transfer master for the 256x8 data-memory port: forward byte copy
// (read then write per byte) or constant fill, started by a one-cycle request.
module mem_block_mover #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_fill_mode,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  input  logic [ADDR_W-1:0] i_length,
  input  logic [DATA_W-1:0] i_fill_value,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_bytes_done,
  output logic              o_mem_read_en,
  output logic              o_mem_write_en,
  output logic [ADDR_W-1:0] o_mem_base_address,
  output logic [ADDR_W-1:0] o_mem_offset_address,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            r_state;
  logic              r_fill;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_len;
  logic [DATA_W-1:0] r_fv;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_hold;
  logic [ADDR_W-1:0] r_bytes_done;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic              w_rd;
  logic              w_wr;

  assign w_idx_nxt = r_idx + 1'b1;
  assign w_rd      = (r_state == S_READ);
  assign w_wr      = (r_state == S_WRITE);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_fill       <= 1'b0;
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_fv         <= '0;
      r_idx        <= '0;
      r_hold       <= '0;
      r_bytes_done <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_fill       <= i_fill_mode;
            r_src        <= i_src_base;
            r_dst        <= i_dst_base;
            r_len        <= i_length;
            r_fv         <= i_fill_value;
            r_idx        <= '0;
            r_bytes_done <= '0;
            if (i_length == '0)  r_state <= S_DONE;
            else if (i_fill_mode) r_state <= S_WRITE;
            else                  r_state <= S_READ;
          end
        end
        S_READ: begin
          r_hold  <= i_mem_rdata;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_idx        <= w_idx_nxt;
          r_bytes_done <= r_bytes_done + 1'b1;
          if (w_idx_nxt == r_len) r_state <= S_DONE;
          else if (!r_fill)       r_state <= S_READ;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory controls decode straight from the state register, so they fall
  // back to zero in IDLE/DONE without any extra clearing.
  assign o_busy               = w_rd | w_wr;
  assign o_done               = (r_state == S_DONE);
  assign o_bytes_done         = r_bytes_done;
  assign o_mem_read_en        = w_rd;
  assign o_mem_write_en       = w_wr;
  assign o_mem_base_address   = w_rd ? r_src : (w_wr ? r_dst : '0);
  assign o_mem_offset_address = (w_rd | w_wr) ? r_idx : '0;
  assign o_mem_wdata          = w_wr ? (r_fill ? r_fv : r_hold) : '0;

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover with a behavioural 256x8 memory and a
// scoreboard of expected destination writes.
module tb_mem_block_mover;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       fill_mode = 1'b0;
  logic [7:0] src_base = '0, dst_base = '0, length = '0, fill_value = '0;
  logic       busy, done, mem_read_en, mem_write_en;
  logic [7:0] bytes_done, mem_base_address, mem_offset_address, mem_wdata, mem_rdata;

  logic [7:0] mem  [256];
  logic [7:0] gold [256];
  logic [7:0] addr;

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t sbq[$];
  wr_t e;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  mem_block_mover #(.DATA_W(8), .ADDR_W(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_fill_mode(fill_mode),
    .i_src_base(src_base), .i_dst_base(dst_base), .i_length(length),
    .i_fill_value(fill_value), .o_busy(busy), .o_done(done),
    .o_bytes_done(bytes_done), .o_mem_read_en(mem_read_en),
    .o_mem_write_en(mem_write_en), .o_mem_base_address(mem_base_address),
    .o_mem_offset_address(mem_offset_address), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: wrapping base+offset, garbage on the read bus unless read_en.
  assign addr      = mem_base_address + mem_offset_address;
  assign mem_rdata = mem_read_en ? mem[addr] : 8'hEE;
  always @(posedge clk) if (mem_write_en) mem[addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("rd_wr_exclusive", {31'b0, mem_read_en & mem_write_en}, 32'd0);
      if (mem_write_en) begin
        if (sbq.size() == 0) chk("sb_unexpected_write", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("sb_addr", {24'b0, addr}, {24'b0, e.addr});
          chk("sb_data", {24'b0, mem_wdata}, {24'b0, e.data});
        end
      end
    end
  end

  task automatic start_xfer(input bit fm, input logic [7:0] src, input logic [7:0] dst,
                            input logic [7:0] len, input logic [7:0] fv, input int nexp);
    logic [7:0] sa, da, d;
    for (int i = 0; i < nexp; i++) begin
      sa = src + 8'(i);
      da = dst + 8'(i);
      d  = fm ? fv : gold[sa];
      gold[da] = d;
      sbq.push_back('{addr: da, data: d});
    end
    fill_mode = fm; src_base = src; dst_base = dst; length = len; fill_value = fv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  {31'b0, busy}, 32'd0);
    chk({tag, "_done"},  {31'b0, done}, 32'd0);
    chk({tag, "_bd"},    {24'b0, bytes_done}, 32'd0);
    chk({tag, "_re"},    {31'b0, mem_read_en}, 32'd0);
    chk({tag, "_we"},    {31'b0, mem_write_en}, 32'd0);
    chk({tag, "_base"},  {24'b0, mem_base_address}, 32'd0);
    chk({tag, "_off"},   {24'b0, mem_offset_address}, 32'd0);
    chk({tag, "_wdata"}, {24'b0, mem_wdata}, 32'd0);
  endtask

  // Walks cycles 1..done checking the expected per-cycle schedule; optional
  // start injection and reset at given cycles (0 = none).
  task automatic watch(input bit fm, input int len, input logic [7:0] src,
                       input logic [7:0] dst, input int inj, input int rstc);
    int dc;
    bit ere, ewe;
    dc = (len == 0) ? 1 : (fm ? len + 1 : 2 * len + 1);
    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      ere = !fm && (c <= 2 * len) && (c % 2 == 1);
      ewe = fm ? (c <= len) : ((c <= 2 * len) && (c % 2 == 0));
      chk("read_en",  {31'b0, mem_read_en},  {31'b0, ere});
      chk("write_en", {31'b0, mem_write_en}, {31'b0, ewe});
      chk("busy",     {31'b0, busy},         {31'b0, ere | ewe});
      chk("done",     {31'b0, done},         {31'b0, c == dc});
      if (ere | ewe) begin
        chk("offset", {24'b0, mem_offset_address}, 32'(fm ? c - 1 : (c - 1) / 2));
        chk("base",   {24'b0, mem_base_address},   {24'b0, ere ? src : dst});
      end
      if (c == dc) chk("bytes_done", {24'b0, bytes_done}, 32'(len));
      if (c == inj) begin
        start = 1'b1; fill_mode = 1'b1; dst_base = 8'h64; length = 8'd9; fill_value = 8'h77;
      end else if (c == inj + 1) start = 1'b0;
      if (c == rstc) begin
        reset = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        reset = 1'b1;
        return;
      end
    end
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_done", {31'b0, done}, 32'd0);
    chk("idle_bd_hold", {24'b0, bytes_done}, 32'(len));
  endtask

  task automatic mem_cmp(input string tag);
    int n = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) n++;
    chk({tag, "_mem"}, 32'(n), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i) ^ 8'h5C;
      gold[i] = 8'(i) ^ 8'h5C;
    end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    chk_zero("post_reset");
    mon_en = 1'b1;

    // Copy 4 bytes 10 -> 200
    mem[10] = 8'hA1; mem[11] = 8'hB2; mem[12] = 8'hC3; mem[13] = 8'hD4;
    gold[10] = 8'hA1; gold[11] = 8'hB2; gold[12] = 8'hC3; gold[13] = 8'hD4;
    start_xfer(1'b0, 8'd10, 8'd200, 8'd4, 8'h00, 4);
    watch(1'b0, 4, 8'd10, 8'd200, 0, 0);
    chk("copy_m200", {24'b0, mem[200]}, 32'hA1);
    chk("copy_m203", {24'b0, mem[203]}, 32'hD4);
    chk("copy_sb_empty", 32'(sbq.size()), 32'd0);
    mem_cmp("copy");

    // Fill with wrap past 255
    start_xfer(1'b1, 8'd0, 8'd254, 8'd4, 8'h5A, 4);
    watch(1'b1, 4, 8'd0, 8'd254, 0, 0);
    chk("fill_m254", {24'b0, mem[254]}, 32'h5A);
    chk("fill_m255", {24'b0, mem[255]}, 32'h5A);
    chk("fill_m0",   {24'b0, mem[0]},   32'h5A);
    chk("fill_m1",   {24'b0, mem[1]},   32'h5A);
    chk("fill_sb_empty", 32'(sbq.size()), 32'd0);
    mem_cmp("fill");

    // Zero length: only a done pulse
    start_xfer(1'b0, 8'd30, 8'd31, 8'd0, 8'h00, 0);
    watch(1'b0, 0, 8'd30, 8'd31, 0, 0);
    mem_cmp("zero");

    // Start pulsed mid-copy with different arguments is ignored
    mem[40] = 8'h11; mem[41] = 8'h22; mem[42] = 8'h33;
    gold[40] = 8'h11; gold[41] = 8'h22; gold[42] = 8'h33;
    start_xfer(1'b0, 8'd40, 8'd60, 8'd3, 8'h00, 3);
    watch(1'b0, 3, 8'd40, 8'd60, 2, 0);
    chk("busy_start_sb_empty", 32'(sbq.size()), 32'd0);
    chk("busy_start_m62", {24'b0, mem[62]}, 32'h33);
    mem_cmp("busy_start");

    // Overlapping forward copy
    mem[20] = 8'h01; mem[21] = 8'h02; mem[22] = 8'h03;
    gold[20] = 8'h01; gold[21] = 8'h02; gold[22] = 8'h03;
    start_xfer(1'b0, 8'd20, 8'd21, 8'd2, 8'h00, 2);
    watch(1'b0, 2, 8'd20, 8'd21, 0, 0);
    chk("ovl_m21", {24'b0, mem[21]}, 32'h01);
    chk("ovl_m22", {24'b0, mem[22]}, 32'h01);
    mem_cmp("ovl");

    // Reset during cycle 5 of an 8-byte copy: only two bytes land
    start_xfer(1'b0, 8'd100, 8'd130, 8'd8, 8'h00, 8);
    watch(1'b0, 8, 8'd100, 8'd130, 0, 5);
    chk("rst_sb_left", 32'(sbq.size()), 32'd6);
    sbq.delete();
    for (int i = 2; i < 8; i++) gold[130 + i] = 8'(130 + i) ^ 8'h5C;
    chk("rst_m131", {24'b0, mem[131]}, {24'b0, 8'(101) ^ 8'h5C});
    chk("rst_m132_untouched", {24'b0, mem[132]}, {24'b0, 8'(132) ^ 8'h5C});
    mem_cmp("rst");

    // Normal run after the reset
    start_xfer(1'b0, 8'd10, 8'd150, 8'd2, 8'h00, 2);
    watch(1'b0, 2, 8'd10, 8'd150, 0, 0);
    chk("after_rst_m150", {24'b0, mem[150]}, 32'hA1);
    chk("after_rst_sb_empty", 32'(sbq.size()), 32'd0);
    mem_cmp("after_rst");

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
